// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encodings and timing defaults for the loader
package imem_loader_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } ldr_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/imem_loader_rx.sv
// rtl/imem_loader_rx.sv - 8N1 serial byte receiver with input synchroniser
module uart_rx_byte
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       CLOCK,
    input  logic       arst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]       sync_q;
    logic             prev_q;
    logic [1:0]       warm_q, warm_d;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_s;

    assign rx_s      = sync_q[1];
    assign byte_data = shift_q;

    always_ff @(posedge CLOCK or posedge arst) begin
        if (arst) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            warm_q  <= 2'd0;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            prev_q  <= sync_q[1];
            warm_q  <= warm_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_valid = 1'b0;
        frame_err  = 1'b0;
        // Edges only count once the synchroniser holds real line samples, so a
        // start bit already low when reset lifts is never mistaken for a new one.
        warm_d     = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (warm_q == 2'd3 && prev_q && !rx_s) begin
                    state_d = RX_START;
                    cnt_d   = CNT_W'(1);
                end
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (cnt_q == LAST) begin
                    state_d    = RX_IDLE;
                    byte_valid = rx_s;
                    frame_err  = !rx_s;
                end
            end
        endcase
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - serial instruction-memory loader holding the core in reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int ADDR_W       = 7,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic              CLOCK,
    input  logic              arst,
    input  logic              uart_rx,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WIDTH-1:0]  imem_wdata,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    ldr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  wdata_q, wdata_d;
    logic [31:0]       asm_q, asm_d;
    logic [1:0]        bidx_q, bidx_d;
    logic              byte_valid, frame_err;
    logic [7:0]        byte_data;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .CLOCK      (CLOCK),
        .arst       (arst),
        .rx         (uart_rx),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    always_ff @(posedge CLOCK or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            bidx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            asm_q   <= asm_d;
            bidx_q  <= bidx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        asm_d   = asm_q;
        bidx_d  = bidx_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (load_req) begin
                    state_d = ST_LEN;
                    cnt_d   = '0;
                    bidx_d  = '0;
                end
            end
            ST_LEN: begin
                if (frame_err) begin
                    state_d = ST_ERR;
                end else if (byte_valid) begin
                    // A count of zero wraps to 2^ADDR_W because the counter is compared after wrapping.
                    len_d   = ADDR_W'(byte_data);
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (frame_err) begin
                    state_d = ST_ERR;
                end else if (byte_valid) begin
                    asm_d[{bidx_q, 3'b000} +: 8] = byte_data;
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        state_d = ST_WRITE;
                        addr_d  = cnt_q;
                        wdata_d = WIDTH'(asm_d);
                    end
                end
            end
            ST_WRITE: begin
                cnt_d   = cnt_q + ADDR_W'(1);
                state_d = (cnt_d == len_q) ? ST_DONE : ST_DATA;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign imem_we    = (state_q == ST_WRITE);
    assign busy       = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_WRITE);
    assign core_rst   = busy || (state_q == ST_ERR);
    assign done       = (state_q == ST_DONE);
    assign err        = (state_q == ST_ERR);
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - scoreboard bench for imem_loader
module tb_imem_loader;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 7;
    localparam int CPB    = 4;
    localparam int T      = 10;

    logic              CLOCK = 1'b0;
    logic              arst;
    logic              uart_rx;
    logic              load_req;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WIDTH-1:0]  imem_wdata;
    logic              core_rst, busy, done, err;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  vectors     = 0;
    int  miscompares = 0;
    int  n_writes    = 0;
    int  writes_base;
    time last_stop_mid = 0;

    imem_loader #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CLKS_PER_BIT(CPB)) dut (
        .CLOCK      (CLOCK),
        .arst       (arst),
        .uart_rx    (uart_rx),
        .load_req   (load_req),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #(T/2) CLOCK = ~CLOCK;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        @(negedge CLOCK);
        uart_rx = 1'b0;
        repeat (CPB-1) @(negedge CLOCK);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK);
            uart_rx = b[i];
            repeat (CPB-1) @(negedge CLOCK);
        end
        @(negedge CLOCK);
        uart_rx = stop_ok;
        last_stop_mid = $time + CPB*T/2;
        repeat (CPB-1) @(negedge CLOCK);
        @(negedge CLOCK);
        uart_rx = 1'b1;
        if (!stop_ok) repeat (CPB) @(negedge CLOCK);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [ADDR_W-1:0] a);
        exp_q.push_back({a, w});
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic pulse_load();
        @(negedge CLOCK);
        load_req = 1'b1;
        @(negedge CLOCK);
        load_req = 1'b0;
    endtask

    always @(negedge CLOCK) begin
        if (imem_we === 1'b1) begin
            n_writes++;
            check_eq("we_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check_eq("wr_addr", imem_addr, mon_e.addr);
                check_eq("wr_data", imem_wdata, mon_e.data);
            end
            check_eq("we_latency", 64'(($time - last_stop_mid) <= 3*T), 64'd1);
        end
    end

    initial begin
        #(T*60000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        arst = 1'b1; uart_rx = 1'b1; load_req = 1'b0;
        repeat (3) @(negedge CLOCK);
        check_eq("rst_we", imem_we, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_core_rst", core_rst, 0);
        check_eq("rst_addr", imem_addr, 0);
        check_eq("rst_wdata", imem_wdata, 0);
        @(negedge CLOCK);
        arst = 1'b0;
        repeat (4) @(negedge CLOCK);

        // normal two-word load
        pulse_load();
        check_eq("load_busy", busy, 1);
        check_eq("load_core_rst", core_rst, 1);
        send_byte(8'h02, 1'b1);
        send_word(32'h20080013, 0);
        send_word(32'h2109FFFF, 1);
        repeat (4) @(negedge CLOCK);
        check_eq("norm_done", done, 1);
        check_eq("norm_core_rst", core_rst, 0);
        check_eq("norm_busy", busy, 0);
        check_eq("norm_sb_empty", exp_q.size(), 0);

        // framing error on third byte of word 1, then recovery with ignored load_req
        pulse_load();
        check_eq("reload_clears_done", done, 0);
        send_byte(8'h02, 1'b1);
        send_word(32'h44332211, 0);
        send_byte(8'h55, 1'b1);
        send_byte(8'h66, 1'b1);
        send_byte(8'h77, 1'b0);
        repeat (4) @(negedge CLOCK);
        check_eq("ferr_err", err, 1);
        check_eq("ferr_core_rst", core_rst, 1);
        check_eq("ferr_busy", busy, 0);
        check_eq("ferr_sb_empty", exp_q.size(), 0);
        pulse_load();
        check_eq("ferr_cleared", err, 0);
        check_eq("ferr_reload_busy", busy, 1);
        send_byte(8'h03, 1'b1);
        send_word(32'hDEADBEEF, 0);
        fork
            send_word(32'h01234567, 1);
            begin
                repeat (10) @(negedge CLOCK);
                pulse_load();
            end
        join
        send_word(32'h89ABCDEF, 2);
        repeat (4) @(negedge CLOCK);
        check_eq("ignore_req_done", done, 1);
        check_eq("ignore_req_sb_empty", exp_q.size(), 0);

        // one-cycle glitch while waiting for the length byte
        pulse_load();
        @(negedge CLOCK);
        uart_rx = 1'b0;
        @(negedge CLOCK);
        uart_rx = 1'b1;
        repeat (20) @(negedge CLOCK);
        check_eq("glitch_busy", busy, 1);
        check_eq("glitch_done", done, 0);
        send_byte(8'h01, 1'b1);
        send_word(32'hCAFEF00D, 0);
        repeat (4) @(negedge CLOCK);
        check_eq("glitch_done_after", done, 1);

        // asynchronous reset during the fifth byte, released mid start bit
        pulse_load();
        send_byte(8'h02, 1'b1);
        send_word(32'h0BADC0DE, 0);
        fork
            send_byte(8'h00, 1'b1);
            begin
                repeat (2) @(negedge CLOCK);
                #3 arst = 1'b1;
                #1;
                check_eq("arst_we", imem_we, 0);
                check_eq("arst_busy", busy, 0);
                check_eq("arst_done", done, 0);
                check_eq("arst_err", err, 0);
                check_eq("arst_core_rst", core_rst, 0);
                check_eq("arst_addr", imem_addr, 0);
                check_eq("arst_wdata", imem_wdata, 0);
                @(negedge CLOCK);
                arst = 1'b0;
                repeat (3) @(negedge CLOCK);
                check_eq("post_arst_busy", busy, 0);
                check_eq("post_arst_core_rst", core_rst, 0);
                pulse_load();
            end
        join
        repeat (8) @(negedge CLOCK);
        send_byte(8'h01, 1'b1);
        send_word(32'h12345678, 0);
        repeat (4) @(negedge CLOCK);
        check_eq("post_arst_done", done, 1);
        check_eq("post_arst_sb_empty", exp_q.size(), 0);

        // N=0: full 2^ADDR_W words
        writes_base = n_writes;
        pulse_load();
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 128; i++) begin
            if (i == 127) begin
                check_eq("full_not_done_early", done, 0);
                check_eq("full_busy_early", busy, 1);
            end
            send_word((32'(i) * 32'h01010101) ^ 32'h5A00C300, ADDR_W'(i));
        end
        repeat (4) @(negedge CLOCK);
        check_eq("full_done", done, 1);
        check_eq("full_writes", n_writes - writes_base, 128);
        check_eq("full_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
